tile_c_collect: RTL and testbench
=================================

Name: tile_c_collect

Overview:
- Downstream stage of the TMUL row engine.
- Captures the packed FP16 row products it emits, one 512-bit row per accepted beat, into a ping-pong C-tile buffer (2 banks x ROWS rows).
- Streams each completed tile to the store/writeback path row by row with valid/ready backpressure.
- Decouples TMUL throughput from the consumer: one tile can fill while the other drains.

Parameters:
- ROWS, 16, rows per C tile; power of two, >=2.
- COLS, 32, FP16 elements per row.
- DW, 16, element width in bits; row width RW = COLS*DW = 512.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  row product valid from TMUL.
- in_ready  out  1  collector can accept a row this cycle.
- in_row  in  RW  packed row product; element m at [(m+1)*DW-1 : m*DW].
- out_valid  out  1  a stored row is presented.
- out_ready  in  1  consumer accepts the presented row.
- out_row  out  RW  presented row data.
- out_idx  out  log2(ROWS)  row index within the tile, 0..ROWS-1.
- out_last  out  1  presented row is the final row of the tile.
- tile_done  out  1  one-cycle pulse after the last row of a tile is accepted.
- tile_cnt  out  16  count of fully drained tiles, wraps at 65535->0.

Behaviour:
- Storage: flop array mem[2][ROWS] of RW bits. Per-bank full flag. Write pointer (wbank, wcnt). Read pointer (rbank, rcnt).
- Reset (rst=0, async):
  - full[0]=full[1]=0; wbank=rbank=0; wcnt=rcnt=0.
  - tile_done=0, tile_cnt=0, out_valid=0, out_row=0, out_idx=0, out_last=0.
  - in_ready=1 from the first cycle after reset release.
  - mem contents are not cleared.
- in_ready = !full[wbank] (combinational).
- Write accept (in_valid & in_ready):
  - mem[wbank][wcnt] <= in_row; wcnt increments.
  - If wcnt==ROWS-1: full[wbank]<=1, wbank toggles, wcnt<=0.
- in_valid while in_ready=0: no state change. Upstream holds the row.
- out_valid = full[rbank].
- Presented outputs:
  - out_row = mem[rbank][rcnt], out_idx = rcnt, out_last = (rcnt==ROWS-1), all gated by out_valid.
  - All are 0 when out_valid=0.
- Read accept (out_valid & out_ready):
  - rcnt increments.
  - If out_last: full[rbank]<=0, rbank toggles, rcnt<=0; tile_done=1 next cycle; tile_cnt increments.
- Latency:
  - A tile becomes readable (out_valid=1) the cycle after its last row is written.
  - The freed bank is writable (in_ready=1) the cycle after its last row is read.
- Stability: while out_valid=1 and out_ready=0, out_row/out_idx/out_last hold constant.
- Simultaneous events:
  - A write closing one bank and a read freeing the other bank in the same cycle both take effect.
  - A bank is never written while full and never read while not full, so no same-bank hazard exists.
- Both banks full: in_ready=0 until the drain of rbank completes. No row is ever dropped or overwritten.
- Reset mid-tile: all partial rows and full flags are discarded; the next accepted row is row 0 of bank 0.
- Throughput: sustains 1 row/cycle in and 1 row/cycle out concurrently in steady state.

Optional Feature:
- Macro TILE_C_COLLECT_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit, level-sampled).
  - flush=1 with wcnt>0 and !full[wbank] closes the current bank early: full set, a per-bank length register stores the row count (wcnt, or wcnt+1 if a write is accepted the same cycle), wbank toggles, wcnt<=0.
  - Drain of that bank asserts out_last on row length-1.
  - flush with wcnt==0 is ignored.
- Undefined: no flush port; every tile is exactly ROWS rows.

Test Plan:
- Reset then idle: after rst released -> in_ready=1, out_valid=0, out_row=0, tile_cnt=0.
- Fill one tile: 16 back-to-back rows with element0 = row number (0x0000..0x000F), out_ready=0 -> out_valid=1 on the cycle after row 15; out_idx=0; out_row[15:0]=0x0000; in_ready stays 1 (bank 1 free).
- Drain: out_ready=1 after the fill -> 16 rows out in order, out_row[15:0]=0x0000..0x000F, out_last only at idx 15; tile_done pulses once; tile_cnt=1.
- Backpressure: write 32 rows with out_ready=0 -> in_ready=0 after the 32nd accept. 33rd row (0xBEEF in all elements) is held, not lost. Release out_ready -> 0xBEEF appears as row 0 of tile 3 after tiles 1 and 2 drain.
- Concurrent streaming: in_valid=1 and out_ready=1 continuously for 64 rows with random data -> output sequence equals input sequence; tile_cnt=3 once the 4th tile is still draining; no in_ready gap longer than 1 cycle.
- Reset mid-tile: 7 rows written, rst pulsed low asynchronously mid-cycle -> outputs 0 immediately. The next 16 rows form tile 0 with out_idx 0..15 and no stale data. With TILE_C_COLLECT_FLUSH_EN: 5 rows then flush -> 5 rows out, out_last on idx 4.

Source files
------------

// File: rtl/tile_c_collect.sv
// Ping-pong C-tile collector between the TMUL row engine and writeback.
// Optional early tile close via TILE_C_COLLECT_FLUSH_EN (adds a flush port).
module tile_c_collect #(
    parameter int ROWS = 16,
    parameter int COLS = 32,
    parameter int DW   = 16,
    localparam int RW  = COLS * DW,
    localparam int IW  = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
`ifdef TILE_C_COLLECT_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RW-1:0] in_row,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_row,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          tile_done,
    output logic [15:0]   tile_cnt
);

    logic [RW-1:0] mem [2][ROWS];
    logic [1:0]    full;
    logic          wBank;
    logic          rBank;
    logic [IW-1:0] wCnt;
    logic [IW-1:0] rCnt;
    logic          wrAcc;
    logic          rdAcc;
    logic          wrapW;
    logic          closeW;
    logic          rowLast;
    logic          tileDone;
    logic [15:0]   tileCnt;

    assign in_ready  = !full[wBank];
    assign out_valid = full[rBank];
    assign wrAcc     = in_valid && in_ready;
    assign rdAcc     = out_valid && out_ready;
    assign wrapW     = wrAcc && (wCnt == IW'(ROWS - 1));

`ifdef TILE_C_COLLECT_FLUSH_EN
    // Index of the final row per bank; short when a bank is flushed early.
    logic [IW-1:0] lastIdx [2];
    logic          flushClose;
    logic [IW-1:0] closeIdx;

    assign flushClose = flush && (wCnt != '0) && !full[wBank];
    assign closeW     = wrapW || flushClose;
    assign closeIdx   = wrAcc ? wCnt : wCnt - 1'b1;
    assign rowLast    = (rCnt == lastIdx[rBank]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastIdx[0] <= '1;
            lastIdx[1] <= '1;
        end else if (closeW) begin
            lastIdx[wBank] <= closeIdx;
        end
    end
`else
    assign closeW  = wrapW;
    assign rowLast = (rCnt == IW'(ROWS - 1));
`endif

    // Row storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wrAcc) begin
            mem[wBank][wCnt] <= in_row;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full     <= '0;
            wBank    <= 1'b0;
            rBank    <= 1'b0;
            wCnt     <= '0;
            rCnt     <= '0;
            tileDone <= 1'b0;
            tileCnt  <= '0;
        end else begin
            tileDone <= rdAcc && rowLast;
            if (closeW) begin
                full[wBank] <= 1'b1;
                wBank       <= !wBank;
                wCnt        <= '0;
            end else if (wrAcc) begin
                wCnt <= wCnt + 1'b1;
            end
            // Read and write never target the same bank in one cycle.
            if (rdAcc) begin
                if (rowLast) begin
                    full[rBank] <= 1'b0;
                    rBank       <= !rBank;
                    rCnt        <= '0;
                    tileCnt     <= tileCnt + 1'b1;
                end else begin
                    rCnt <= rCnt + 1'b1;
                end
            end
        end
    end

    assign out_row   = out_valid ? mem[rBank][rCnt] : '0;
    assign out_idx   = out_valid ? rCnt : '0;
    assign out_last  = out_valid && rowLast;
    assign tile_done = tileDone;
    assign tile_cnt  = tileCnt;

endmodule

// File: tb/tb_tile_c_collect.sv
// Randomized bench for tile_c_collect against a tile/row queue model.
// Build with TILE_C_COLLECT_FLUSH_EN to also exercise early tile close.
module tb_tile_c_collect;

    localparam int ROWS = 16;
    localparam int COLS = 32;
    localparam int DW   = 16;
    localparam int RW   = COLS * DW;
    localparam int IW   = $clog2(ROWS);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [RW-1:0] in_row = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [RW-1:0] out_row;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          tile_done;
    logic [15:0]   tile_cnt;
    logic          flush = 1'b0;

    always #5 clk = ~clk;

    tile_c_collect #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef TILE_C_COLLECT_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .tile_done (tile_done),
        .tile_cnt  (tile_cnt)
    );

    // Model: every accepted row in order, plus lengths of closed tiles.
    logic [RW-1:0] rowQ[$];
    int            lenQ[$];
    int            wOpen;
    int            rPos;
    int            drained;
    bit            doneExp;
    int            nChk;
    int            nPass;

    task automatic chk(input string tag, input logic [RW-1:0] obs,
                       input logic [RW-1:0] exp);
        nChk++;
        if (obs === exp) nPass++;
        else $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    endtask

    function automatic logic [RW-1:0] randRow();
        logic [RW-1:0] r;
        for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic modelReset();
        rowQ.delete();
        lenQ.delete();
        wOpen   = 0;
        rPos    = 0;
        drained = 0;
        doneExp = 1'b0;
    endtask

    task automatic step(input bit iv, input logic [RW-1:0] row,
                        input bit ordy, input bit fl);
        bit rdyE;
        bit valE;
        bit inAcc;
        bit outAcc;
        int len;
        in_valid  = iv;
        in_row    = row;
        out_ready = ordy;
        flush     = fl;
        #1;
        rdyE = lenQ.size() < 2;
        valE = lenQ.size() > 0;
        chk("in_ready", RW'(in_ready), RW'(rdyE));
        chk("out_valid", RW'(out_valid), RW'(valE));
        chk("out_row", out_row, valE ? rowQ[0] : '0);
        chk("out_idx", RW'(out_idx), valE ? RW'(rPos) : '0);
        chk("out_last", RW'(out_last),
            RW'(valE && rPos == lenQ[0] - 1));
        chk("tile_done", RW'(tile_done), RW'(doneExp));
        chk("tile_cnt", RW'(tile_cnt), RW'(drained % 65536));
        inAcc  = iv && rdyE;
        outAcc = ordy && valE;
        len    = 0;
`ifdef TILE_C_COLLECT_FLUSH_EN
        if (fl && wOpen > 0 && rdyE) len = wOpen + int'(inAcc);
`endif
        if (inAcc && wOpen + 1 == ROWS) len = ROWS;
        doneExp = 1'b0;
        if (outAcc) begin
            void'(rowQ.pop_front());
            if (rPos == lenQ[0] - 1) begin
                void'(lenQ.pop_front());
                rPos    = 0;
                drained++;
                doneExp = 1'b1;
            end else begin
                rPos++;
            end
        end
        if (inAcc) begin
            rowQ.push_back(row);
            wOpen++;
        end
        if (len > 0) begin
            lenQ.push_back(len);
            wOpen = 0;
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [RW-1:0] beef;
        bit sent;
        bit rdy;
        nChk  = 0;
        nPass = 0;
        beef  = {(RW / 16){16'hBEEF}};
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);

        for (int i = 0; i < ROWS; i++) step(1'b1, RW'(i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        drain(ROWS + 2);

        for (int i = 0; i < 2 * ROWS; i++)
            step(1'b1, randRow(), 1'b0, 1'b0);
        repeat (3) step(1'b1, beef, 1'b0, 1'b0);
        sent = 1'b0;
        for (int k = 0; k < 200 && !sent; k++) begin
            rdy = lenQ.size() < 2;
            step(1'b1, beef, 1'b1, 1'b0);
            if (rdy) sent = 1'b1;
        end
        chk("beef_accepted", RW'(sent), RW'(1'b1));
        for (int i = 1; i < ROWS; i++) step(1'b1, randRow(), 1'b1, 1'b0);
        drain(3 * ROWS);

        for (int i = 0; i < 4 * ROWS; i++)
            step(1'b1, randRow(), 1'b1, 1'b0);
        drain(2 * ROWS);

        for (int i = 0; i < 400; i++)
            step(1'($urandom % 2), randRow(), ($urandom % 4) != 0,
                 ($urandom % 16) == 0);
        drain(3 * ROWS);

        for (int i = 0; i < ROWS + 7; i++)
            step(1'b1, randRow(), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_out_valid", RW'(out_valid), '0);
        chk("rst_out_row", out_row, '0);
        chk("rst_in_ready", RW'(in_ready), RW'(1'b1));
        chk("rst_tile_cnt", RW'(tile_cnt), '0);
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        for (int i = 0; i < ROWS; i++) step(1'b1, randRow(), 1'b0, 1'b0);
        drain(ROWS + 2);

`ifdef TILE_C_COLLECT_FLUSH_EN
        for (int i = 0; i < 5; i++) step(1'b1, randRow(), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        drain(8);
        for (int i = 0; i < 3; i++) step(1'b1, randRow(), 1'b0, 1'b0);
        step(1'b1, randRow(), 1'b1, 1'b1);
        drain(8);
`endif

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
